wb_cmd_master: RTL and testbench

Wishbone classic-cycle master that turns a simple valid/ready command stream into single-beat register accesses on the SPI core's Wishbone slave port. It sits directly upstream of that port. Write/read commands are buffered in a small FIFO and issued one at a time, with a cycle timeout. Each access returns exactly one response (read data plus status) on a valid/ready response stream.

---
 rtl/wb_cmd_master.sv | 159 +++++++++++++++
 tb/tb_wb_cmd_master.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: queues register commands and issues each one as a
// single Wishbone classic cycle, returning one data/status response.
// Ports:
//   wb_clk_i, wb_rst_i        clock, sync active-high reset
//   cmd_valid/ready/we/adr/dat/sel   command stream (FIFO input)
//   rsp_valid/ready/dat/status/we    response stream
//   wb_adr_o/dat_o/sel_o/we_o/stb_o/cyc_o, wb_dat_i/ack_i/err_i
//                              Wishbone master side
module wb_cmd_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [4:0]  cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_status,
  output logic        rsp_we,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 42;
  localparam logic [AW:0] FULL_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_e;

  state_e        state_q;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          rdy_q;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic [7:0]    tmo_q;

  // ready is registered from the next occupancy, so a pop in the
  // same cycle as a full FIFO never admits a push
  assign cmd_ready = rdy_q;
  assign push      = cmd_valid & rdy_q;
  assign pop       = (state_q == S_IDLE) && (cnt_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_we, cmd_adr, cmd_dat, cmd_sel};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != FULL_C);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      tmo_q      <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      wb_we_o    <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_cyc_o   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_status <= '0;
      rsp_we     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            wb_we_o  <= head[41];
            wb_adr_o <= head[40:36];
            wb_dat_o <= head[41] ? head[35:4] : 32'd0;
            wb_sel_o <= head[3:0];
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            tmo_q    <= '0;
            state_q  <= S_BUS;
          end
        end
        S_BUS: begin
          if (wb_err_i || wb_ack_i ||
              (tmo_q == TMO_LAST)) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_we    <= wb_we_o;
            // err beats ack beats timeout
            if (wb_err_i) begin
              rsp_status <= 2'b01;
              rsp_dat    <= '0;
            end else if (wb_ack_i) begin
              rsp_status <= 2'b00;
              rsp_dat    <= wb_we_o ? 32'd0 : wb_dat_i;
            end else begin
              rsp_status <= 2'b10;
              rsp_dat    <= '0;
            end
            state_q <= S_RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed and random checks of wb_cmd_master
// against a queue-based command/response model and a slave model.
module tb_wb_cmd_master;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  typedef struct packed {
    logic        we;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } cmd_t;

  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  st;
    logic        we;
  } rsp_t;

  typedef struct packed {
    logic [7:0] d;
    logic       err;
  } cfg_t;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [4:0]  cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        rsp_we;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  always #5 clk = ~clk;

  wb_cmd_master #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_dat    (cmd_dat),
    .cmd_sel    (cmd_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dat    (rsp_dat),
    .rsp_status (rsp_status),
    .rsp_we     (rsp_we),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  cmd_t cmd_q[$];
  rsp_t exp_q[$];
  cfg_t cfg_q[$];
  logic [31:0] smem [32];

  int pushed = 0;
  int popped = 0;
  int edge_n = 0;
  int acc_edge = 0;
  int rsp_rise_edge = 0;
  int rsp_rises = 0;
  int stb_rise_edge = 0;
  int stb_fall_edge = 0;
  int stb_rises = 0;
  logic rand_bp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    if ($urandom_range(0, 15) == 0) c.d = 8'd0;
    else if ($urandom_range(0, 9) == 0) c.d = 8'(TMO);
    else c.d = 8'($urandom_range(1, 4));
    c.err = ($urandom_range(0, 7) == 0);
    return c;
  endfunction

  // Slave: picks a response delay per cycle (0 = silent) and
  // predicts the master's response from the timeout rules.
  initial begin : slave
    int n;
    int d;
    logic err;
    logic busy;
    logic upd;
    logic [31:0] rdat;
    cmd_t cur;
    cfg_t cf;
    rsp_t e;
    n = 0; d = 0; err = 0; busy = 0; upd = 0; rdat = 0; cur = '0;
    wb_ack_i = 0; wb_err_i = 0; wb_dat_i = 0;
    forever begin
      @(posedge clk);
      #1;
      wb_ack_i = 0;
      wb_err_i = 0;
      wb_dat_i = $urandom;
      if (wb_rst_i) begin
        busy = 0;
      end else begin
        if (busy) begin
          n++;
        end else if (wb_stb_o) begin
          popped++;
          if (cmd_q.size() == 0) begin
            chk("spurious_cycle", 32'(wb_stb_o), 32'd0);
          end else begin
            cur = cmd_q.pop_front();
            chk("bus_adr", 32'(wb_adr_o), 32'(cur.adr));
            chk("bus_we", 32'(wb_we_o), 32'(cur.we));
            chk("bus_sel", 32'(wb_sel_o), 32'(cur.sel));
            chk("bus_dat", wb_dat_o, cur.we ? cur.dat : 32'd0);
            if (cfg_q.size() != 0) cf = cfg_q.pop_front();
            else cf = rand_cfg();
            busy = 1; n = 1; d = int'(cf.d); err = cf.err;
            rdat = smem[cur.adr];
            e.we = cur.we;
            if (d == 0 || d > TMO) begin
              e.st = 2'b10; e.dat = 0;
            end else if (err) begin
              e.st = 2'b01; e.dat = 0;
            end else begin
              e.st = 2'b00; e.dat = cur.we ? 32'd0 : rdat;
            end
            upd = (e.st == 2'b00) && cur.we;
            exp_q.push_back(e);
          end
        end
        if (busy && n == d) begin
          wb_ack_i = 1;
          wb_err_i = err;
          wb_dat_i = cur.we ? $urandom : rdat;
          if (upd) begin
            for (int b = 0; b < 4; b++)
              if (cur.sel[b])
                smem[cur.adr][8*b +: 8] = cur.dat[8*b +: 8];
          end
          busy = 0;
        end else if (busy && d == 0 && !wb_stb_o) begin
          busy = 0;
        end
      end
    end
  end

  // Monitor: response scoreboard, hold/stability and ready checks.
  initial begin : monitor
    logic pv, pstb, pwo, pwe;
    logic [31:0] pdat, pdo;
    logic [1:0] pst;
    logic [4:0] padr;
    logic [3:0] psel;
    int gap;
    rsp_t e;
    pv = 0; pstb = 0; pwo = 0; pwe = 0; pdat = 0; pdo = 0;
    pst = 0; padr = 0; psel = 0; gap = 99;
    forever begin
      @(posedge clk);
      edge_n++;
      #3;
      if (wb_rst_i) begin
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("rst_rsp_we", 32'(rsp_we), 32'd0);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_adr", 32'(wb_adr_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_sel", 32'(wb_sel_o), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        exp_q.delete();
        cmd_q.delete();
        cfg_q.delete();
        pushed = 0;
        popped = 0;
      end else begin
        if (pv && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'(pv), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_dat", pdat, e.dat);
            chk("rsp_status", 32'(pst), 32'(e.st));
            chk("rsp_we", 32'(pwe), 32'(e.we));
          end
          chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        end else if (pv) begin
          chk("hold_valid", 32'(rsp_valid), 32'd1);
          chk("hold_dat", rsp_dat, pdat);
          chk("hold_status", 32'(rsp_status), 32'(pst));
          chk("hold_we", 32'(rsp_we), 32'(pwe));
        end
        if (!pv && rsp_valid) begin
          rsp_rise_edge = edge_n;
          rsp_rises++;
        end
        chk("cmd_ready", 32'(cmd_ready),
            32'((pushed - popped) != DEPTH));
        chk("cyc_eq_stb", 32'(wb_cyc_o), 32'(wb_stb_o));
        if (pstb && wb_stb_o) begin
          chk("bus_hold_adr", 32'(wb_adr_o), 32'(padr));
          chk("bus_hold_dat", wb_dat_o, pdo);
          chk("bus_hold_sel", 32'(wb_sel_o), 32'(psel));
          chk("bus_hold_we", 32'(wb_we_o), 32'(pwo));
        end
        if (!pstb && wb_stb_o) begin
          chk("cyc_gap", 32'(gap >= 2), 32'd1);
          stb_rise_edge = edge_n;
          stb_rises++;
        end
        if (pstb && !wb_stb_o) stb_fall_edge = edge_n;
      end
      gap = wb_cyc_o ? 0 : ((gap < 99) ? gap + 1 : 99);
      pv = rsp_valid; pdat = rsp_dat; pst = rsp_status;
      pwe = rsp_we; pstb = wb_stb_o; padr = wb_adr_o;
      pdo = wb_dat_o; psel = wb_sel_o; pwo = wb_we_o;
    end
  end

  initial begin : backpressure
    forever begin
      @(negedge clk);
      if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input cmd_t c);
    int k;
    logic took;
    k = 0;
    took = 0;
    cmd_valid = 1;
    {cmd_we, cmd_adr, cmd_dat, cmd_sel} = c;
    while (!took && k < 500) begin
      took = cmd_ready;
      @(posedge clk);
      #1;
      if (took) begin
        cmd_q.push_back(c);
        pushed++;
        acc_edge = edge_n;
      end
      @(negedge clk);
      k++;
    end
    cmd_valid = 0;
    cmd_we = 1'($urandom);
    cmd_adr = 5'($urandom);
    cmd_dat = $urandom;
    cmd_sel = 4'($urandom);
    chk("push_accept", 32'(took), 32'd1);
  endtask

  task automatic wait_rsp();
    int k;
    k = 0;
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_wait", 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain();
    int k;
    logic done;
    k = 0;
    done = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
      done = (cmd_q.size() == 0) && (exp_q.size() == 0) &&
             (cfg_q.size() == 0) && !rsp_valid && !wb_cyc_o;
    end
    chk("drain", 32'(done), 32'd1);
  endtask

  function automatic cmd_t mk(input logic we, input logic [4:0] a,
                              input logic [31:0] dv,
                              input logic [3:0] s);
    cmd_t c;
    c.we = we; c.adr = a; c.dat = dv; c.sel = s;
    return c;
  endfunction

  initial begin : main
    int r0;
    int q0;
    cmd_t c;
    wb_rst_i = 1; cmd_valid = 0; rsp_ready = 1;
    cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0;
    for (int i = 0; i < 32; i++) smem[i] = $urandom;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_cyc", 32'(wb_cyc_o), 32'd0);
    wb_rst_i = 0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // single write, slave acks one cycle after strobe
    cfg_q.push_back('{d: 8'd2, err: 1'b0});
    push(mk(1'b1, 5'h10, 32'h0000_2200, 4'hF));
    wait_rsp();
    chk("wr_latency", 32'(rsp_rise_edge - acc_edge), 32'd3);
    chk("wr_status", 32'(rsp_status), 32'd0);
    chk("wr_we", 32'(rsp_we), 32'd1);
    chk("wr_dat", rsp_dat, 32'd0);
    drain();

    // read-back of the same register
    cfg_q.push_back('{d: 8'd2, err: 1'b0});
    push(mk(1'b0, 5'h10, 32'hDEAD_BEEF, 4'hF));
    wait_rsp();
    chk("rd_dat", rsp_dat, 32'h0000_2200);
    chk("rd_status", 32'(rsp_status), 32'd0);
    chk("rd_we", 32'(rsp_we), 32'd0);
    drain();

    // fill the FIFO behind a stalled response
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cfg_q.push_back('{d: 8'd2, err: 1'b0});
      c = mk(1'($urandom), 5'(i * 7 + 1), $urandom, 4'($urandom));
      push(c);
    end
    chk("fifo_full_ready", 32'(cmd_ready), 32'd0);
    chk("fifo_full_occ", 32'(pushed - popped), 32'(DEPTH));
    rsp_ready = 1;
    drain();

    // err together with ack
    cfg_q.push_back('{d: 8'd2, err: 1'b1});
    push(mk(1'b0, 5'h03, 32'h0, 4'hF));
    wait_rsp();
    chk("err_status", 32'(rsp_status), 32'd1);
    chk("err_dat", rsp_dat, 32'd0);
    drain();

    // ack arriving on the timeout edge completes ok
    cfg_q.push_back('{d: 8'(TMO), err: 1'b0});
    push(mk(1'b0, 5'h10, 32'h0, 4'hF));
    wait_rsp();
    chk("tmo_edge_status", 32'(rsp_status), 32'd0);
    chk("tmo_edge_dat", rsp_dat, 32'h0000_2200);
    drain();

    // silent slave, then a late ack while the response waits
    rsp_ready = 0;
    cfg_q.push_back('{d: 8'(TMO + 3), err: 1'b0});
    push(mk(1'b1, 5'h05, 32'h1234_5678, 4'hF));
    wait_rsp();
    chk("tmo_status", 32'(rsp_status), 32'd2);
    chk("tmo_stb_len", 32'(stb_fall_edge - stb_rise_edge), 32'(TMO));
    repeat (6) @(negedge clk);
    chk("tmo_late_hold", 32'(rsp_status), 32'd2);
    rsp_ready = 1;
    cfg_q.push_back('{d: 8'd2, err: 1'b0});
    push(mk(1'b0, 5'h10, 32'h0, 4'hF));
    wait_rsp();
    chk("after_tmo_status", 32'(rsp_status), 32'd0);
    drain();

    // response backpressure for 10 cycles
    rsp_ready = 0;
    cfg_q.push_back('{d: 8'd2, err: 1'b0});
    cfg_q.push_back('{d: 8'd2, err: 1'b0});
    push(mk(1'b1, 5'h07, 32'hCAFE_0001, 4'h3));
    push(mk(1'b0, 5'h07, 32'h0, 4'hF));
    wait_rsp();
    r0 = stb_rises;
    repeat (10) @(negedge clk);
    chk("bp_no_new_cyc", 32'(stb_rises), 32'(r0));
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1;
    drain();

    // reset while a silent cycle is on the bus with 2 queued
    for (int i = 0; i < 3; i++) cfg_q.push_back('{d: 8'd0, err: 1'b0});
    for (int i = 0; i < 3; i++) push(mk(1'b1, 5'(i), $urandom, 4'hF));
    chk("rst_mid_stb", 32'(wb_stb_o), 32'd1);
    chk("rst_mid_queued", 32'(pushed - popped), 32'd2);
    r0 = stb_rises;
    q0 = rsp_rises;
    wb_rst_i = 1;
    @(negedge clk);
    wb_rst_i = 0;
    chk("rst_mid_stb_low", 32'(wb_stb_o), 32'd0);
    @(negedge clk);
    chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
    repeat (30) @(negedge clk);
    chk("rst_no_reissue", 32'(stb_rises), 32'(r0));
    chk("rst_no_rsp", 32'(rsp_rises), 32'(q0));

    // random traffic with random backpressure and slave behaviour
    rand_bp = 1;
    for (int i = 0; i < 80; i++) begin
      c = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             $urandom, 4'($urandom_range(0, 15)));
      push(c);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_bp = 0;
    rsp_ready = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
